// File: rtl/rca_8bit_pkg.sv
// Shared constants and bit-level helpers for the ripple-carry adder slice.
//
// Contents:
//   RCA_WIDTH  default operand width of rca_8bit
//   faSum      sum bit of a single full-adder stage
//   faCarry    carry-out bit of a single full-adder stage
package rca_8bit_pkg;

  localparam int RCA_WIDTH = 8;

  // Sum of one stage: odd parity of the three inputs.
  function automatic logic faSum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Carry of one stage: generate when both operands are set, otherwise
  // propagate the incoming carry when exactly one operand is set.
  function automatic logic faCarry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

endpackage

// File: rtl/rca_8bit_full_adder.sv
// One-bit full adder, purely combinational; one link of the ripple chain.
//
// Ports:
//   a, b  operand bits
//   cin   carry from the previous (less significant) stage
//   s     sum bit
//   cout  carry into the next (more significant) stage
module full_adder
  import rca_8bit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = faSum(a, b, cin);
  assign cout = faCarry(a, b, cin);

endmodule

// File: rtl/rca_8bit.sv
// Unsigned ripple-carry adder with a single output register stage.
// The combinational sum is captured on every rising edge, so a result
// appears one cycle after its operands and operands may change every cycle.
//
// Ports:
//   clk   clock, all state on the rising edge
//   rst   synchronous active-high reset, clears all outputs
//   a, b  unsigned operands (WIDTH bits), not registered on entry
//   sum   registered (a+b) mod 2^WIDTH
//   cout  registered carry-out of the most significant stage
//   out   registered full result {cout, sum}
module rca_8bit
  import rca_8bit_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH:0]   out
);

  logic [WIDTH:0]   carryChain;
  logic [WIDTH-1:0] sumComb;
  logic [WIDTH:0]   result_d;
  logic [WIDTH:0]   result_q;

  // There is no carry-in port; the chain starts from zero.
  assign carryChain[0] = 1'b0;

  // Linear ripple of full adders, each stage feeding the next stage's carry.
  for (genvar i = 0; i < WIDTH; i++) begin : gStage
    full_adder uFa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carryChain[i]),
      .s    (sumComb[i]),
      .cout (carryChain[i+1])
    );
  end

  // The complete result is assembled before the register so that sum, cout
  // and out all come from one flop vector and can never disagree.
  always_comb begin
    result_d = {carryChain[WIDTH], sumComb};
  end

  // Single output stage; reset wins over whatever operands are present.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign sum  = result_q[WIDTH-1:0];
  assign cout = result_q[WIDTH];
  assign out  = result_q;

endmodule

// File: tb/tb_rca_8bit.sv
// Scoreboard bench for rca_8bit: the driver applies one directed vector per
// cycle and queues its hand-computed result; an independent monitor pops
// one expectation after every rising edge and compares all three outputs.
module tb_rca_8bit;

  typedef struct {
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expSum;
    logic       expCout;
    logic [8:0] expOut;
  } vector_t;

  typedef struct {
    logic [7:0] expSum;
    logic       expCout;
    logic [8:0] expOut;
  } expect_t;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] sum;
  logic       cout;
  logic [8:0] out;

  expect_t scoreboard[$];
  int      checks = 0;
  int      errors = 0;
  int      resultIdx = 0;

  rca_8bit #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .sum  (sum),
    .cout (cout),
    .out  (out)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one vector and queue the result it must produce after the next edge.
  task automatic applyStimulus(input vector_t v);
    expect_t e;
    rst = v.rst;
    a   = v.a;
    b   = v.b;
    e.expSum  = v.expSum;
    e.expCout = v.expCout;
    e.expOut  = v.expOut;
    scoreboard.push_back(e);
  endtask

  // Compare the registered outputs against one queued expectation.
  task automatic checkOutput(input expect_t e, input int idx);
    checks++;
    if (sum !== e.expSum) begin
      errors++;
      $display("[TB] FAIL sum[%0d] got %0d expected %0d", idx, sum, e.expSum);
    end
    checks++;
    if (cout !== e.expCout) begin
      errors++;
      $display("[TB] FAIL cout[%0d] got %0b expected %0b", idx, cout, e.expCout);
    end
    checks++;
    if (out !== e.expOut) begin
      errors++;
      $display("[TB] FAIL out[%0d] got %0d expected %0d", idx, out, e.expOut);
    end
  endtask

  // Monitor: the adder presents a fresh result after every rising edge.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #2;
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput(e, resultIdx);
        resultIdx++;
      end
    end
  end

  // Driver: directed vectors, one per cycle, results hand-computed.
  initial begin
    vector_t vecs[$];
    vecs = '{
      '{1'b1, 8'hFF, 8'hFF, 8'd0,   1'b0, 9'd0},
      '{1'b1, 8'hFF, 8'hFF, 8'd0,   1'b0, 9'd0},
      '{1'b0, 8'd10, 8'd20, 8'd30,  1'b0, 9'd30},
      '{1'b0, 8'd14, 8'd1,  8'd15,  1'b0, 9'd15},
      '{1'b0, 8'd5,  8'd0,  8'd5,   1'b0, 9'd5},
      '{1'b0, 8'd0,  8'd0,  8'd0,   1'b0, 9'd0},
      '{1'b0, 8'd99, 8'd23, 8'd122, 1'b0, 9'd122},
      '{1'b0, 8'd127,8'd127,8'd254, 1'b0, 9'd254},
      '{1'b0, 8'd255,8'd255,8'd254, 1'b1, 9'd510},
      '{1'b0, 8'd255,8'd1,  8'd0,   1'b1, 9'd256},
      '{1'b1, 8'd200,8'd100,8'd0,   1'b0, 9'd0},
      '{1'b0, 8'd200,8'd100,8'd44,  1'b1, 9'd300},
      '{1'b0, 8'd15, 8'd1,  8'd16,  1'b0, 9'd16},
      '{1'b0, 8'd85, 8'd85, 8'd170, 1'b0, 9'd170},
      '{1'b0, 8'd128,8'd128,8'd0,   1'b1, 9'd256},
      '{1'b0, 8'd170,8'd85, 8'd255, 1'b0, 9'd255},
      '{1'b0, 8'd1,  8'd2,  8'd3,   1'b0, 9'd3},
      '{1'b0, 8'd3,  8'd4,  8'd7,   1'b0, 9'd7},
      '{1'b0, 8'd64, 8'd192,8'd0,   1'b1, 9'd256},
      '{1'b0, 8'd7,  8'd9,  8'd16,  1'b0, 9'd16}
    };
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (scoreboard.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain left %0d expected 0", scoreboard.size());
    end
    checks++;
    if (resultIdx != vecs.size()) begin
      errors++;
      $display("[TB] FAIL results got %0d expected %0d", resultIdx, vecs.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
